// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-Lite bus bundle between a master (core bridge / bench) and axi_lite_ram_slave.
interface axi_lite_ram_slave_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTES-1:0]      wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave over a byte-lane word RAM with base/size window decode (DECERR outside).
// Optional macro AXI_RAM_MISALIGN_CHK_EN: misaligned addresses get SLVERR instead of accessing the word.
module axi_lite_ram_lane #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [7:0]       wbyte,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [7:0]       rbyte
);
    logic [7:0] mem [DEPTH];

    // Read and write share an edge; the NBA ordering gives read-before-write.
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wbyte;
        if (re) rbyte <= mem[ridx];
    end
endmodule

module axi_lite_ram_slave #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
    input logic                   clk,
    input logic                   rst,
    axi_lite_ram_slave_if.slave   s
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WIN = ADDR_WIDTH'(MEM_DEPTH * BYTES);

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    function automatic logic [1:0] dec_resp(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [ADDR_WIDTH-1:0] off);
        if (a < BASE_ADDR || off >= WIN) return DECERR;
`ifdef AXI_RAM_MISALIGN_CHK_EN
        if (off[OFF_W-1:0] != '0) return SLVERR;
`endif
        return OKAY;
    endfunction

    // ---------------- write channel ----------------
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    w_state_t w_state, w_next;

    logic                  aw_got, w_got;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BYTES-1:0]      w_strb_q;
    logic [1:0]            bresp_q;

    logic                  aw_hs, w_hs, b_hs, commit;
    logic [ADDR_WIDTH-1:0] wa, wa_off;
    logic [DATA_WIDTH-1:0] wd;
    logic [BYTES-1:0]      ws;
    logic [1:0]            w_resp;
    logic [IDX_W-1:0]      w_idx;

    assign s.awready = (w_state == W_IDLE) & ~aw_got;
    assign s.wready  = (w_state == W_IDLE) & ~w_got;
    assign s.bvalid  = (w_state == W_RESP);
    assign s.bresp   = bresp_q;

    assign aw_hs = s.awvalid & s.awready;
    assign w_hs  = s.wvalid & s.wready;
    assign b_hs  = s.bvalid & s.bready;

    // Each half comes from its latch if it arrived earlier, else straight off the bus.
    assign wa     = aw_got ? aw_addr_q : s.awaddr;
    assign wd     = w_got ? w_data_q : s.wdata;
    assign ws     = w_got ? w_strb_q : s.wstrb;
    assign wa_off = wa - BASE_ADDR;
    assign w_resp = dec_resp(wa, wa_off);
    assign w_idx  = wa_off[OFF_W +: IDX_W];
    assign commit = (w_state == W_IDLE) & (aw_got | aw_hs) & (w_got | w_hs) & ~rst;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (commit) w_next = W_RESP;
            W_RESP: if (b_hs)   w_next = W_IDLE;
            default:            w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            bresp_q <= OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= s.awaddr;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_data_q <= s.wdata;
                w_strb_q <= s.wstrb;
            end
            if (commit) bresp_q <= w_resp;
            if (b_hs) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    // ---------------- read channel ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t r_state, r_next;

    logic                  ar_hs, r_ok;
    logic [ADDR_WIDTH-1:0] ar_off;
    logic [1:0]            r_resp_d, rresp_q;
    logic [IDX_W-1:0]      r_idx;
    logic [BYTES-1:0][7:0] lane_rd;

    assign s.arready = (r_state == R_IDLE);
    assign s.rvalid  = (r_state == R_DATA);
    assign s.rresp   = rresp_q;
    // Error responses and reset present zero without touching the RAM output register.
    assign s.rdata   = r_ok ? lane_rd : '0;

    assign ar_hs    = s.arvalid & s.arready;
    assign ar_off   = s.araddr - BASE_ADDR;
    assign r_resp_d = dec_resp(s.araddr, ar_off);
    assign r_idx    = ar_off[OFF_W +: IDX_W];

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs)              r_next = R_DATA;
            R_DATA: if (s.rvalid & s.rready) r_next = R_IDLE;
            default:                        r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rresp_q <= OKAY;
            r_ok    <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rresp_q <= r_resp_d;
                r_ok    <= (r_resp_d == OKAY);
            end
        end
    end

    // ---------------- byte-lane storage ----------------
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        axi_lite_ram_lane #(.DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_lane (
            .clk   (clk),
            .we    (commit & (w_resp == OKAY) & ws[b]),
            .widx  (w_idx),
            .wbyte (wd[8*b +: 8]),
            .re    (ar_hs & (r_resp_d == OKAY)),
            .ridx  (r_idx),
            .rbyte (lane_rd[b])
        );
    end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Randomized + directed bench for axi_lite_ram_slave against a word-map reference model.
module tb_axi_lite_ram_slave;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] WIN  = 64'h8000;   // 4096 words * 8 bytes

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_ram_slave_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_lite_ram_slave #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(4096), .BASE_ADDR(BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] mdl [int];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_resp(input logic [63:0] a);
        if (a < BASE || a >= BASE + WIN) return 2'b11;
`ifdef AXI_RAM_MISALIGN_CHK_EN
        if (a[2:0] != 3'd0) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        if (m_resp(a) != 2'b00) return;
        w = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[m_idx(a)] = w;
    endtask

    function automatic logic [63:0] m_read(input logic [63:0] a);
        if (m_resp(a) != 2'b00) return 64'h0;
        return mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 64'h0;
    endfunction

    // AW is offered from cycle aw_at, W from cycle w_at; bready stays high.
    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int aw_at, input int w_at);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int c = 0;
        logic [1:0] er = m_resp(a);
        while (!(aw_done && w_done) && c < 20) begin
            @(negedge clk);
            bus.awaddr  = a;
            bus.wdata   = d;
            bus.wstrb   = s;
            bus.awvalid = (c >= aw_at) && !aw_done;
            bus.wvalid  = (c >= w_at) && !w_done;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            chk("bvalid_early", bus.bvalid, 1'b0);
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            c++;
        end
        if (!(aw_done && w_done)) chk("wr_timeout", 1'b0, 1'b1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("bvalid", bus.bvalid, 1'b1);
        chk("bresp", bus.bresp, er);
        @(posedge clk);
        @(negedge clk);
        chk("bvalid_clr", bus.bvalid, 1'b0);
        m_write(a, d, s);
    endtask

    task automatic axi_read(input logic [63:0] a);
        @(negedge clk);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        chk("arready", bus.arready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        chk("rvalid", bus.rvalid, 1'b1);
        chk("rdata", bus.rdata, m_read(a));
        chk("rresp", bus.rresp, m_resp(a));
        @(posedge clk);
        @(negedge clk);
        chk("rvalid_clr", bus.rvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, d, old;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 1;  bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_bresp", bus.bresp, 2'b00);
        chk("rst_rresp", bus.rresp, 2'b00);
        chk("rst_rdata", bus.rdata, 64'h0);
        chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // same-cycle AW+W then read back
        axi_write(64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, 0);
        axi_read(64'h8000_0010);
        // W first, AW three cycles later, partial strobe
        axi_write(64'h8000_0010, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 3, 0);
        chk("merge_model", m_read(64'h8000_0010), 64'h11223344BBBBBBBB);
        axi_read(64'h8000_0010);

        for (int i = 0; i < 16; i++)
            axi_write(BASE + 64'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 0);
        axi_write(BASE + WIN - 8, {$urandom, $urandom}, 8'hFF, 0, 0);
        axi_write(64'h8000_0020, 64'h0, 8'hFF, 0, 0);
        axi_read(BASE + WIN - 8);

        // bready held low for 5 cycles while a read runs alongside
        @(negedge clk);
        bus.bready = 0;
        bus.awaddr = 64'h8000_0030; bus.wdata = 64'hCAFE_F00D_1234_5678; bus.wstrb = 8'hFF;
        bus.awvalid = 1; bus.wvalid = 1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        bus.araddr = 64'h8000_0010; bus.arvalid = 1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_bvalid", bus.bvalid, 1'b1);
            chk("hold_bresp", bus.bresp, 2'b00);
            chk("hold_wrdy", {bus.awready, bus.wready}, 2'b00);
            if (k == 0) chk("hold_arready", bus.arready, 1'b1);
            if (k == 1) begin
                chk("hold_rvalid", bus.rvalid, 1'b1);
                chk("hold_rdata", bus.rdata, m_read(64'h8000_0010));
            end
            if (k == 2) chk("hold_rvalid_clr", bus.rvalid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            if (k == 0) bus.arvalid = 0;
        end
        bus.bready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_bvalid_clr", bus.bvalid, 1'b0);
        chk("hold_wrdy_back", {bus.awready, bus.wready}, 2'b11);
        m_write(64'h8000_0030, 64'hCAFE_F00D_1234_5678, 8'hFF);
        axi_read(64'h8000_0030);

        // window edges: below base and one past the top (aliases word 0 if mis-decoded)
        axi_read(64'h7FFF_FFF8);
        axi_write(64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        axi_read(64'h8000_0000);
        axi_write(64'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 1, 0);
        axi_read(BASE + WIN - 8);
        axi_write(64'h8000_0040, 64'h9999_9999_9999_9999, 8'h00, 0, 2);
        axi_read(64'h8000_0040);

        // write commit and read sample on the same edge
        @(negedge clk);
        bus.awaddr = 64'h8000_0020; bus.wdata = 64'hDEAD; bus.wstrb = 8'hFF;
        bus.awvalid = 1; bus.wvalid = 1;
        bus.araddr = 64'h8000_0020; bus.arvalid = 1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        chk("rbw_rvalid", bus.rvalid, 1'b1);
        chk("rbw_rdata", bus.rdata, 64'h0);
        chk("rbw_bvalid", bus.bvalid, 1'b1);
        @(posedge clk);
        m_write(64'h8000_0020, 64'hDEAD, 8'hFF);
        axi_read(64'h8000_0020);

        // reset while both responses are pending
        @(negedge clk);
        bus.bready = 0; bus.rready = 0;
        d = {$urandom, $urandom};
        bus.awaddr = 64'h8000_0038; bus.wdata = d; bus.wstrb = 8'hFF;
        bus.awvalid = 1; bus.wvalid = 1;
        bus.araddr = 64'h8000_0018; bus.arvalid = 1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        chk("pre_rst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
        m_write(64'h8000_0038, d, 8'hFF);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("mid_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("mid_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("mid_rst_rdata", bus.rdata, 64'h0);
        bus.bready = 1; bus.rready = 1;
        axi_read(64'h8000_0038);
        axi_read(64'h8000_0018);

        // a commit edge that coincides with reset must not write
        @(negedge clk);
        old = m_read(64'h8000_0048);
        rst = 1;
        bus.awaddr = 64'h8000_0048; bus.wdata = ~old; bus.wstrb = 8'hFF;
        bus.awvalid = 1; bus.wvalid = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        bus.awvalid = 0; bus.wvalid = 0;
        chk("rst_commit_bvalid", bus.bvalid, 1'b0);
        chk("rst_commit_readies", {bus.awready, bus.wready}, 2'b11);
        axi_read(64'h8000_0048);

        // misaligned read (SLVERR only when the check is built in)
        axi_read(64'h8000_0004);

        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 64'(8 * (1 + $urandom_range(0, 3)));
            else if (r == 1) a = BASE + WIN + 64'(8 * $urandom_range(0, 15));
            else a = BASE + 64'(8 * $urandom_range(0, 15)) +
                     64'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
            if ($urandom_range(0, 2) != 0)
                axi_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a);
        end
        for (int i = 0; i < 16; i++) axi_read(BASE + 64'(i * 8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
